master_bridge_sync_fifo: RTL and testbench
==========================================

Name: master_bridge_sync_fifo

Overview:
Single-clock, parametrised FIFO for intra-domain buffering inside the master bridge, for example between the request decoder and the AXI channel drivers once clock-domain crossing is done. It generalises the bridge's FIFO family with several additions:
- occupancy count output;
- programmable almost-full and almost-empty thresholds;
- selectable first-word-fall-through (FWFT) or registered-read mode;
- synchronous flush;
- sticky overflow and underflow error flags.

Parameters:
DATA_WIDTH, 32, width of each stored word.
ADDR_WIDTH, 3, address bits; FIFO_DEPTH must equal 2**ADDR_WIDTH.
FIFO_DEPTH, 8, number of entries.
CNT_WIDTH, ADDR_WIDTH+1, width of the occupancy count (range 0..FIFO_DEPTH).
AFULL_THRESH, FIFO_DEPTH-2, almost-full asserts when count >= this value.
AEMPTY_THRESH, 1, almost-empty asserts when count <= this value.
FWFT, 1, 1 = head word visible at o_r_data with 0-cycle read latency; 0 = registered read with 1-cycle latency.

Ports:
i_clk  in  1  single clock; all state updates on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_flush  in  1  synchronous clear of contents, count and error flags.
i_w_inc  in  1  write request.
i_w_data  in  DATA_WIDTH  write data.
i_r_inc  in  1  read request (pop).
o_r_data  out  DATA_WIDTH  read data.
o_r_valid  out  1  FWFT=1: equals !empty. FWFT=0: one-cycle pulse the cycle after an accepted read.
o_w_full_flag  out  1  count == FIFO_DEPTH.
o_r_empty_flag  out  1  count == 0.
o_almost_full  out  1  count >= AFULL_THRESH.
o_almost_empty  out  1  count <= AEMPTY_THRESH.
o_count  out  CNT_WIDTH  current occupancy.
o_overflow  out  1  sticky; a write was attempted while full.
o_underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (i_rst=1, asynchronous): pointers=0, count=0, memory contents don't-care.
  - Outputs: empty=1, full=0, almost_full=0, almost_empty=1, o_r_data=0, o_r_valid=0, overflow=0, underflow=0.
  - Reset mid-transfer discards all data; the first cycle after deassertion is a normal idle cycle.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from FIFO_DEPTH-1 to 0. Full and empty derive from count, not from pointer comparison.
- Write accept: wr_acc = i_w_inc & !full.
  - When accepted: mem[wr_ptr] <= i_w_data, wr_ptr++.
  - i_w_inc while full: write dropped, o_overflow <= 1. This holds even if a read is accepted in the same cycle (no write-through at full).
- Read accept: rd_acc = i_r_inc & !empty. When accepted: rd_ptr++.
  - i_r_inc while empty: ignored, o_underflow <= 1. No write bypass at empty, even with a simultaneous write.
- Count update:
  - +1 on wr_acc & !rd_acc;
  - -1 on rd_acc & !wr_acc;
  - unchanged when both or neither are accepted.
  - Flags are combinational from the registered count and therefore update in the cycle after the accepting edge.
- FWFT=1: o_r_data = mem[rd_ptr] combinationally whenever !empty, and holds the last value or don't-care when empty. A word written at edge N is visible, with o_r_valid=1, in cycle N+1.
- FWFT=0: on rd_acc, o_r_data <= mem[rd_ptr] and o_r_valid <= 1 for one cycle. o_r_data holds its value until the next accepted read.
- Flush (i_flush=1): at the clock edge, pointers=0, count=0, overflow/underflow=0, o_r_valid=0.
  - Flush has priority over any write or read requested in the same cycle; those requests are discarded and do not set error flags.
  - o_r_data is not cleared.
- Thresholds are compared unsigned on CNT_WIDTH bits. AFULL_THRESH=0 makes o_almost_full constant 1 after reset.
- Throughput: with both sides active and 0 < count < FIFO_DEPTH, one write and one read are accepted per cycle.

Test Plan:
1. Reset then fill: DATA_WIDTH=32, depth 8, FWFT=1. Write 0x00..0x07 on consecutive cycles.
   - count goes 1..8; almost_full rises when count reaches 6; full=1 at count=8.
   - A 9th write sets overflow=1 and count stays 8.
2. Drain: after test 1, hold i_r_inc for 8 cycles.
   - o_r_data is 0x00..0x07 in order; empty=1 after the 8th pop.
   - A 9th pop sets underflow=1 and count stays 0.
3. Wrap and concurrent access: pre-load 3 words, then write and read together for 20 cycles.
   - count stays 3; data order is preserved across pointer wrap; no error flags set.
4. FWFT=0: write 0xA5A5A5A5, then pulse i_r_inc.
   - o_r_valid pulses exactly 1 cycle later with o_r_data=0xA5A5A5A5, and o_r_data holds afterwards.
5. Flush priority: with count=5 and overflow=1, assert i_flush together with i_w_inc and i_r_inc.
   - Next cycle: count=0, empty=1, overflow=0; the write is not stored.
6. Async reset mid-stream: assert i_rst between clock edges with count=4.
   - All outputs immediately take their reset values without waiting for a clock edge; normal writes resume after deassertion.

Source files
------------

// File: rtl/master_bridge_sync_fifo_if.sv
// Handshake and status bundle for the master bridge synchronous FIFO.
// The producer/consumer logic uses the master modport; the FIFO uses the slave modport.
interface master_bridge_sync_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 4
);
   logic                  i_flush;
   logic                  i_w_inc;
   logic [DATA_WIDTH-1:0] i_w_data;
   logic                  i_r_inc;
   logic [DATA_WIDTH-1:0] o_r_data;
   logic                  o_r_valid;
   logic                  o_w_full_flag;
   logic                  o_r_empty_flag;
   logic                  o_almost_full;
   logic                  o_almost_empty;
   logic [CNT_WIDTH-1:0]  o_count;
   logic                  o_overflow;
   logic                  o_underflow;

   modport master (
      output i_flush, i_w_inc, i_w_data, i_r_inc,
      input  o_r_data, o_r_valid, o_w_full_flag, o_r_empty_flag,
      input  o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
   );

   modport slave (
      input  i_flush, i_w_inc, i_w_data, i_r_inc,
      output o_r_data, o_r_valid, o_w_full_flag, o_r_empty_flag,
      output o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/master_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, FWFT or
// registered read, synchronous flush and sticky overflow/underflow flags.
module master_bridge_sync_fifo #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned CNT_WIDTH     = ADDR_WIDTH + 1,
   parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = 1,
   parameter bit          FWFT          = 1'b1
) (
   input logic                      i_clk,
   input logic                      i_rst,
   master_bridge_sync_fifo_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] DepthCnt  = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] AfullCnt  = CNT_WIDTH'(AFULL_THRESH);
   localparam logic [CNT_WIDTH-1:0] AemptyCnt = CNT_WIDTH'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  full, empty, wr_acc, rd_acc;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);

   // Flush wins over both sides, so neither request is accepted in a flush cycle.
   assign wr_acc = bus.i_w_inc & ~full & ~bus.i_flush;
   assign rd_acc = bus.i_r_inc & ~empty & ~bus.i_flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.i_flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_WIDTH'(1);
         end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_WIDTH'(1);
         end
         if (bus.i_w_inc && full)  overflow_d  = 1'b1;
         if (bus.i_r_inc && empty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; contents are meaningless until written.
   always_ff @(posedge i_clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.i_w_data;
   end

   if (FWFT) begin : g_fwft
      always_comb begin
         bus.o_r_data  = empty ? '0 : mem_q[rd_ptr_q];
         bus.o_r_valid = ~empty;
      end
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_data_q;
      logic                  r_valid_q;

      // Flush leaves the last read word in place; only the valid pulse is suppressed.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
         end else begin
            r_valid_q <= rd_acc;
            if (rd_acc) r_data_q <= mem_q[rd_ptr_q];
         end
      end

      always_comb begin
         bus.o_r_data  = r_data_q;
         bus.o_r_valid = r_valid_q;
      end
   end

   always_comb begin
      bus.o_w_full_flag  = full;
      bus.o_r_empty_flag = empty;
      bus.o_almost_full  = (count_q >= AfullCnt);
      bus.o_almost_empty = (count_q <= AemptyCnt);
      bus.o_count        = count_q;
      bus.o_overflow     = overflow_q;
      bus.o_underflow    = underflow_q;
   end

endmodule

// File: tb/tb_master_bridge_sync_fifo.sv
// Directed bench for master_bridge_sync_fifo: one FWFT instance and one
// registered-read instance, checked with immediate assertions.
module tb_master_bridge_sync_fifo;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   master_bridge_sync_fifo_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) fw_if ();
   master_bridge_sync_fifo_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) rg_if ();

   master_bridge_sync_fifo #(.FWFT(1'b1)) u_fwft (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (fw_if)
   );

   master_bridge_sync_fifo #(.FWFT(1'b0)) u_reg (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (rg_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      fw_if.i_flush = 1'b0; fw_if.i_w_inc = 1'b0; fw_if.i_w_data = '0; fw_if.i_r_inc = 1'b0;
      rg_if.i_flush = 1'b0; rg_if.i_w_inc = 1'b0; rg_if.i_w_data = '0; rg_if.i_r_inc = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_count", 32'(fw_if.o_count), 32'd0);
      check("rst_empty", 32'(fw_if.o_r_empty_flag), 32'd1);
      check("rst_full", 32'(fw_if.o_w_full_flag), 32'd0);
      check("rst_afull", 32'(fw_if.o_almost_full), 32'd0);
      check("rst_aempty", 32'(fw_if.o_almost_empty), 32'd1);
      check("rst_rdata", fw_if.o_r_data, 32'd0);
      check("rst_rvalid", 32'(fw_if.o_r_valid), 32'd0);
      check("rst_ovf", 32'(fw_if.o_overflow), 32'd0);
      check("rst_udf", 32'(fw_if.o_underflow), 32'd0);
      check("rst_reg_rdata", rg_if.o_r_data, 32'd0);
      check("rst_reg_rvalid", 32'(rg_if.o_r_valid), 32'd0);

      // Fill 0x00..0x07
      fw_if.i_w_inc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         fw_if.i_w_data = 32'(i);
         tick();
         check("fill_count", 32'(fw_if.o_count), 32'(i + 1));
         check("fill_afull", 32'(fw_if.o_almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
         check("fill_aempty", 32'(fw_if.o_almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
         check("fill_full", 32'(fw_if.o_w_full_flag), (i + 1 == 8) ? 32'd1 : 32'd0);
         check("fill_head", fw_if.o_r_data, 32'd0);
      end
      fw_if.i_w_data = 32'h99;
      tick();
      fw_if.i_w_inc = 1'b0;
      check("ovf_set", 32'(fw_if.o_overflow), 32'd1);
      check("ovf_count", 32'(fw_if.o_count), 32'd8);

      // Drain in order
      fw_if.i_r_inc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_data", fw_if.o_r_data, 32'(i));
         check("drain_valid", 32'(fw_if.o_r_valid), 32'd1);
         tick();
      end
      check("drain_empty", 32'(fw_if.o_r_empty_flag), 32'd1);
      check("drain_count", 32'(fw_if.o_count), 32'd0);
      check("drain_udf_pre", 32'(fw_if.o_underflow), 32'd0);
      tick();
      fw_if.i_r_inc = 1'b0;
      check("udf_set", 32'(fw_if.o_underflow), 32'd1);
      check("udf_count", 32'(fw_if.o_count), 32'd0);
      check("ovf_sticky", 32'(fw_if.o_overflow), 32'd1);

      // Flush clears sticky flags
      fw_if.i_flush = 1'b1;
      tick();
      fw_if.i_flush = 1'b0;
      check("flush_ovf", 32'(fw_if.o_overflow), 32'd0);
      check("flush_udf", 32'(fw_if.o_underflow), 32'd0);

      // Wrap with concurrent access
      fw_if.i_w_inc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fw_if.i_w_data = 32'h100 + 32'(k);
         tick();
      end
      check("pre_count", 32'(fw_if.o_count), 32'd3);
      fw_if.i_r_inc = 1'b1;
      for (int j = 0; j < 20; j++) begin
         fw_if.i_w_data = 32'h103 + 32'(j);
         check("wrap_data", fw_if.o_r_data, 32'h100 + 32'(j));
         tick();
         check("wrap_count", 32'(fw_if.o_count), 32'd3);
      end
      fw_if.i_w_inc = 1'b0;
      fw_if.i_r_inc = 1'b0;
      check("wrap_head", fw_if.o_r_data, 32'h114);
      check("wrap_ovf", 32'(fw_if.o_overflow), 32'd0);
      check("wrap_udf", 32'(fw_if.o_underflow), 32'd0);

      // Flush priority with count=5, overflow=1
      fw_if.i_flush = 1'b1;
      tick();
      fw_if.i_flush = 1'b0;
      fw_if.i_w_inc = 1'b1;
      for (int k = 0; k < 9; k++) begin
         fw_if.i_w_data = 32'h200 + 32'(k);
         tick();
      end
      fw_if.i_w_inc = 1'b0;
      fw_if.i_r_inc = 1'b1;
      repeat (3) tick();
      fw_if.i_r_inc = 1'b0;
      check("pf_count", 32'(fw_if.o_count), 32'd5);
      check("pf_ovf", 32'(fw_if.o_overflow), 32'd1);
      check("pf_head", fw_if.o_r_data, 32'h203);
      fw_if.i_flush  = 1'b1;
      fw_if.i_w_inc  = 1'b1;
      fw_if.i_r_inc  = 1'b1;
      fw_if.i_w_data = 32'hDEAD;
      tick();
      fw_if.i_flush = 1'b0;
      fw_if.i_w_inc = 1'b0;
      fw_if.i_r_inc = 1'b0;
      check("fl_count", 32'(fw_if.o_count), 32'd0);
      check("fl_empty", 32'(fw_if.o_r_empty_flag), 32'd1);
      check("fl_ovf", 32'(fw_if.o_overflow), 32'd0);
      check("fl_udf", 32'(fw_if.o_underflow), 32'd0);
      check("fl_rvalid", 32'(fw_if.o_r_valid), 32'd0);
      tick();
      check("fl_idle_count", 32'(fw_if.o_count), 32'd0);

      // Async reset mid-stream with count=4
      fw_if.i_w_inc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fw_if.i_w_data = 32'h300 + 32'(k);
         tick();
      end
      fw_if.i_w_inc = 1'b0;
      check("ar_pre_count", 32'(fw_if.o_count), 32'd4);
      #2 rst = 1'b1;
      #1;
      check("ar_count", 32'(fw_if.o_count), 32'd0);
      check("ar_empty", 32'(fw_if.o_r_empty_flag), 32'd1);
      check("ar_rvalid", 32'(fw_if.o_r_valid), 32'd0);
      check("ar_rdata", fw_if.o_r_data, 32'd0);
      check("ar_aempty", 32'(fw_if.o_almost_empty), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      fw_if.i_w_inc  = 1'b1;
      fw_if.i_w_data = 32'h55;
      tick();
      fw_if.i_w_inc = 1'b0;
      check("ar_resume_count", 32'(fw_if.o_count), 32'd1);
      check("ar_resume_data", fw_if.o_r_data, 32'h55);

      // Registered read mode
      rg_if.i_w_inc  = 1'b1;
      rg_if.i_w_data = 32'hA5A5A5A5;
      tick();
      rg_if.i_w_inc = 1'b0;
      check("rg_count", 32'(rg_if.o_count), 32'd1);
      check("rg_valid_idle", 32'(rg_if.o_r_valid), 32'd0);
      rg_if.i_r_inc = 1'b1;
      tick();
      rg_if.i_r_inc = 1'b0;
      check("rg_valid_pulse", 32'(rg_if.o_r_valid), 32'd1);
      check("rg_data", rg_if.o_r_data, 32'hA5A5A5A5);
      tick();
      check("rg_valid_drop", 32'(rg_if.o_r_valid), 32'd0);
      check("rg_data_hold", rg_if.o_r_data, 32'hA5A5A5A5);
      check("rg_empty", 32'(rg_if.o_r_empty_flag), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
